// File: rtl/modular_halving_unit_if.sv
// Operand/result bundle for the modular halving unit: operands and start in, busy/finish/result out.
// Start is level-sampled and only accepted while the unit is idle.
interface modular_halving_unit_if #(
  parameter int WIDTH = 64,
  parameter int KW    = 7
);
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] p_i;
  logic [KW-1:0]    k_i;
  logic             halving_start_i;
  logic             busy_o;
  logic             finish_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output a_i, p_i, k_i, halving_start_i,
    input  busy_o, finish_o, result_o
  );

  modport slave (
    input  a_i, p_i, k_i, halving_start_i,
    output busy_o, finish_o, result_o
  );
endinterface

// File: rtl/modular_halving_unit.sv
// Iterative (A * 2^-K) mod P for odd P, one halving per clock; finish after K+1 edges (K+2 with
// MODHALF_PRE_REDUCE_EN, which adds one conditional subtract so A may lie in [0, 2P)). Start ignored while busy.
module modular_halving_unit #(
  parameter int WIDTH = 64,
  parameter int KW    = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  modular_halving_unit_if.slave bus
);

`ifdef MODHALF_PRE_REDUCE_EN
  typedef enum logic [1:0] {IDLE, HALVE, DONE, REDUCE} state_t;
`else
  typedef enum logic [1:0] {IDLE, HALVE, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    finish_d = 1'b0;
    result_d = result_q;
    // Extra bit keeps the carry of acc+p as the new MSB after the shift.
    sum      = {1'b0, acc_q} + {1'b0, p_q};

    case (state_q)
      IDLE: begin
        if (bus.halving_start_i) begin
          acc_d  = bus.a_i;
          p_d    = bus.p_i;
          cnt_d  = bus.k_i;
          busy_d = 1'b1;
`ifdef MODHALF_PRE_REDUCE_EN
          state_d = REDUCE;
`else
          state_d = (bus.k_i != '0) ? HALVE : DONE;
`endif
        end
      end
`ifdef MODHALF_PRE_REDUCE_EN
      REDUCE: begin
        if (acc_q >= p_q) acc_d = acc_q - p_q;
        state_d = (cnt_q != '0) ? HALVE : DONE;
      end
`endif
      HALVE: begin
        acc_d = acc_q[0] ? WIDTH'(sum >> 1) : (acc_q >> 1);
        cnt_d = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) state_d = DONE;
      end
      DONE: begin
        result_d = acc_q;
        finish_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o   = busy_q;
  assign bus.finish_o = finish_q;
  assign bus.result_o = result_q;

endmodule
